// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one req/ready memory port between IF and DM (DM priority,
//            IF starvation guard). Optional perf counters: ARB_PERF_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              dm_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        owner
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_conflicts,
    output logic [31:0]       perf_busy
`endif
);

    localparam int c_CNT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

    // Encoding doubles as the owner code driven on the port.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BUSY_IF = 2'b01,
        BUSY_DM = 2'b10
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_mem_req,   w_mem_req_nxt;
    logic                r_mem_we,    w_mem_we_nxt;
    logic [ADDR_W-1:0]   r_mem_addr,  w_mem_addr_nxt;
    logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
    logic                r_if_ack,    w_if_ack_nxt;
    logic                r_dm_ack,    w_dm_ack_nxt;
    logic [DATA_W-1:0]   r_if_rdata,  w_if_rdata_nxt;
    logic [DATA_W-1:0]   r_dm_rdata,  w_dm_rdata_nxt;
    logic [c_CNT_W-1:0]  r_starve_cnt, w_starve_nxt;

    logic w_if_elig;
    logic w_dm_elig;
    logic w_force_if;
    logic w_grant_if;
    logic w_grant_dm;

    // A requester still high in its own ack cycle is not a new request.
    assign w_if_elig  = if_req & ~r_if_ack;
    assign w_dm_elig  = dm_req & ~r_dm_ack;
    assign w_force_if = (STARVE_LIMIT > 0) && w_if_elig && (r_starve_cnt == c_LIMIT);
    assign w_grant_dm = (r_state == IDLE) && w_dm_elig && !w_force_if;
    assign w_grant_if = (r_state == IDLE) && w_if_elig && !w_grant_dm;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state      <= IDLE;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_if_ack     <= 1'b0;
            r_dm_ack     <= 1'b0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_if_ack     <= w_if_ack_nxt;
            r_dm_ack     <= w_dm_ack_nxt;
            r_if_rdata   <= w_if_rdata_nxt;
            r_dm_rdata   <= w_dm_rdata_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_if_ack_nxt    = 1'b0;
        w_dm_ack_nxt    = 1'b0;
        w_if_rdata_nxt  = r_if_rdata;
        w_dm_rdata_nxt  = r_dm_rdata;
        case (r_state)
            IDLE: begin
                if (w_grant_dm) begin
                    w_state_nxt     = BUSY_DM;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = dm_we;
                    w_mem_addr_nxt  = dm_addr;
                    w_mem_wdata_nxt = dm_wdata;
                end else if (w_grant_if) begin
                    w_state_nxt     = BUSY_IF;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_addr_nxt  = if_addr;
                end
            end
            BUSY_IF: begin
                if (mem_ready) begin
                    w_state_nxt    = IDLE;
                    w_mem_req_nxt  = 1'b0;
                    w_if_rdata_nxt = mem_rdata;
                    w_if_ack_nxt   = 1'b1;
                end
            end
            BUSY_DM: begin
                if (mem_ready) begin
                    w_state_nxt   = IDLE;
                    w_mem_req_nxt = 1'b0;
                    w_dm_ack_nxt  = 1'b1;
                    if (!r_mem_we) begin
                        w_dm_rdata_nxt = mem_rdata;
                    end
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (w_grant_if) begin
            w_starve_nxt = '0;
        end else if (w_grant_dm && w_if_elig && (r_starve_cnt != c_LIMIT)) begin
            w_starve_nxt = r_starve_cnt + 1'b1;
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] r_perf_conflicts;
    logic [31:0] r_perf_busy;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_perf_conflicts <= '0;
            r_perf_busy      <= '0;
        end else begin
            if ((r_state == IDLE) && w_if_elig && w_dm_elig) begin
                r_perf_conflicts <= r_perf_conflicts + 32'd1;
            end
            if (r_mem_req) begin
                r_perf_busy <= r_perf_busy + 32'd1;
            end
        end
    end

    assign perf_conflicts = r_perf_conflicts;
    assign perf_busy      = r_perf_busy;
`endif

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_ack    = r_if_ack;
    assign dm_ack    = r_dm_ack;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign if_stall  = if_req & ~r_if_ack;
    assign dm_stall  = dm_req & ~r_dm_ack;
    assign owner     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed + randomized bench for mem_port_arbiter with a
//            transaction-level memory/arbitration model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int c_LIMIT = 4;

    logic        CLK, RST;
    logic        if_req, if_ack, if_stall;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_ack, dm_stall;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  owner;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_conflicts, perf_busy;
`endif

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(c_LIMIT)) dut (
        .CLK(CLK), .RST(RST),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ack(if_ack), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .owner(owner)
`ifdef ARB_PERF_CNT_EN
        , .perf_conflicts(perf_conflicts), .perf_busy(perf_busy)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Reference model: who holds the port, the transaction it carries,
    // remaining memory cycles, expected requester-side results.
    int          m_who;
    int          m_left;
    logic [31:0] m_addr, m_wdata;
    logic        m_we;
    logic        exp_if_ack, exp_dm_ack;
    logic [31:0] exp_if_rdata, exp_dm_rdata;
    int          starve;
    int          exp_conf, exp_busy;
    int          mem_lat;
    logic [31:0] memory [logic [31:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (memory.exists(a)) return memory[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic model_reset();
        m_who = 0; m_left = 0; m_addr = '0; m_wdata = '0; m_we = 1'b0;
        exp_if_ack = 1'b0; exp_dm_ack = 1'b0;
        exp_if_rdata = '0; exp_dm_rdata = '0;
        starve = 0; exp_conf = 0; exp_busy = 0;
    endtask

    // One clock: caller has set requester inputs at the negedge.
    task automatic step();
        logic        g_if, g_dm, rdy, if_el, dm_el, we_dm;
        logic [31:0] a_if, a_dm, wd_dm;
        #1;
        check("if_stall", if_stall, if_req & ~exp_if_ack);
        check("dm_stall", dm_stall, dm_req & ~exp_dm_ack);
        g_if = 1'b0; g_dm = 1'b0; rdy = 1'b0;
        if_el = if_req & ~exp_if_ack;
        dm_el = dm_req & ~exp_dm_ack;
        a_if = if_addr; a_dm = dm_addr; we_dm = dm_we; wd_dm = dm_wdata;
        if (m_who == 0) begin
            if (dm_el && !(if_el && c_LIMIT > 0 && starve == c_LIMIT)) g_dm = 1'b1;
            else if (if_el) g_if = 1'b1;
            if (g_dm && if_el && starve < c_LIMIT) starve++;
            if (g_if) starve = 0;
            if (if_el && dm_el) exp_conf++;
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
        end else begin
            exp_busy++;
            rdy = (m_left == 1);
            m_left--;
            mem_ready = rdy;
            mem_rdata = (rdy && !m_we) ? mem_read(m_addr) : $urandom;
        end
        @(posedge CLK);
        @(negedge CLK);
        exp_if_ack = rdy && (m_who == 1);
        exp_dm_ack = rdy && (m_who == 2);
        if (rdy) begin
            if (m_we) memory[m_addr] = m_wdata;
            else if (m_who == 1) exp_if_rdata = mem_rdata;
            else exp_dm_rdata = mem_rdata;
            m_who = 0;
        end
        if (g_dm) begin
            m_who = 2; m_addr = a_dm; m_we = we_dm; m_wdata = wd_dm;
            m_left = (mem_lat == 0) ? $urandom_range(1, 3) : mem_lat;
        end
        if (g_if) begin
            m_who = 1; m_addr = a_if; m_we = 1'b0;
            m_left = (mem_lat == 0) ? $urandom_range(1, 3) : mem_lat;
        end
        check("if_ack", if_ack, exp_if_ack);
        check("dm_ack", dm_ack, exp_dm_ack);
        check("if_rdata", if_rdata, exp_if_rdata);
        check("dm_rdata", dm_rdata, exp_dm_rdata);
        check("mem_req", mem_req, m_who != 0);
        check("owner", owner, m_who);
        if (m_who != 0) begin
            check("mem_addr", mem_addr, m_addr);
            check("mem_we", mem_we, m_we);
            if (m_we) check("mem_wdata", mem_wdata, m_wdata);
        end
`ifdef ARB_PERF_CNT_EN
        check("perf_conflicts", perf_conflicts, exp_conf);
        check("perf_busy", perf_busy, exp_busy);
`endif
    endtask

    // Complete all outstanding work, each requester dropping on its ack.
    task automatic drain();
        int n = 0;
        while ((if_req || dm_req || m_who != 0) && n < 40) begin
            step();
            n++;
            if (exp_if_ack) if_req = 1'b0;
            if (exp_dm_ack) dm_req = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, dack, iack, conf0, busy0;
        RST = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        model_reset();
        mem_lat = 1;
        repeat (3) @(negedge CLK);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_acks", {if_ack, dm_ack}, 2'b00);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_dm_rdata", dm_rdata, 32'h0);
        check("rst_owner", owner, 2'b00);
`ifdef ARB_PERF_CNT_EN
        check("rst_perf", {perf_conflicts, perf_busy}, 32'h0);
`endif
        RST = 1'b1;

        // Reset while DM owns the port; late mem_ready must be ignored.
        mem_lat = 3;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
        step();
        check("t1_busy_dm", owner, 2'b10);
        #2 RST = 1'b0;
        #1;
        check("t1_async_req", mem_req, 1'b0);
        check("t1_async_owner", owner, 2'b00);
        model_reset();
        dm_req = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        mem_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        mem_ready = 1'b0;
        check("t1_no_ack", {if_ack, dm_ack}, 2'b00);
        check("t1_owner", owner, 2'b00);
        check("t1_mem_req", mem_req, 1'b0);

        // Lone IF read answered in the first memory cycle.
        memory[32'h10] = 32'hDEADBEEF;
        mem_lat = 1;
        if_req = 1'b1; if_addr = 32'h10;
        step();
        check("t2_mem_req", mem_req, 1'b1);
        check("t2_mem_addr", mem_addr, 32'h10);
        check("t2_mem_we", mem_we, 1'b0);
        check("t2_stall_c2", if_stall, 1'b1);
        step();
        check("t2_if_ack", if_ack, 1'b1);
        check("t2_if_rdata", if_rdata, 32'hDEADBEEF);
        check("t2_stall_ack", if_stall, 1'b0);
        if_req = 1'b0;
        step();
        check("t2_ack_pulse", if_ack, 1'b0);

        // Simultaneous IF read and DM write, two-cycle memory.
        mem_lat = 2;
        conf0 = exp_conf; busy0 = exp_busy;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'h55;
        if_req = 1'b1; if_addr = 32'h30;
        cyc = 0; dack = -1; iack = -1;
        while ((dack < 0 || iack < 0) && cyc < 20) begin
            step();
            cyc++;
            if (cyc == 1) begin
                check("t3_dm_first", owner, 2'b10);
                check("t3_we", mem_we, 1'b1);
                check("t3_wdata", mem_wdata, 32'h55);
            end
            if (dm_ack === 1'b1 && dack < 0) begin dack = cyc; dm_req = 1'b0; end
            if (if_ack === 1'b1 && iack < 0) begin iack = cyc; if_req = 1'b0; end
        end
        check("t3_dm_ack_cycle", dack, 3);
        check("t3_if_ack_cycle", iack, 6);
`ifdef ARB_PERF_CNT_EN
        check("t3_perf_conf", perf_conflicts, conf0 + 1);
        check("t3_perf_busy", perf_busy, busy0 + 4);
`endif
        step();

        // DM keeps req high through its ack cycle: no re-issue.
        mem_lat = 1;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
        step();
        step();
        check("t5_dm_ack", dm_ack, 1'b1);
        check("t5_readback", dm_rdata, 32'h55);
        step();
        check("t5_no_reissue", mem_req, 1'b0);
        dm_req = 1'b0;
        step();

        // Starvation guard: IF loses four contended grants, wins the fifth.
        for (int r = 0; r < 6; r++) begin
            if_req = 1'b1; if_addr = 32'h40;
            dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100 + 32'(r * 4);
            step();
            if (r == 4) check("t4_if_forced", owner, 2'b01);
            else check("t4_dm_wins", owner, 2'b10);
            if (r != 4) if_req = 1'b0;
            drain();
            step();
        end

        // Randomized traffic against the model.
        mem_lat = 0;
        for (int i = 0; i < 400; i++) begin
            if (!if_req || exp_if_ack) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = 32'($urandom_range(0, 15)) * 4;
            end else if (m_who != 1 && $urandom_range(0, 15) == 0) begin
                if_req = 1'b0;
            end
            if (!dm_req || exp_dm_ack) begin
                dm_req   = ($urandom_range(0, 2) != 0);
                dm_we    = 1'($urandom_range(0, 1));
                dm_addr  = 32'($urandom_range(0, 15)) * 4;
                dm_wdata = $urandom;
            end
            step();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
